// File: rtl/audio_fx_pkg.sv
// Shared types and constants for the audio effects chain (gate, compressor, limiter, meter).
package audio_fx_pkg;

    localparam int SAMPLE_W   = 16;
    localparam int GAIN_SHIFT = 8;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic [8:0]                 gain_t;

    localparam gain_t GAIN_ONE = 9'd256;

    typedef enum logic [2:0] {
        CLOSED,
        ATTACK,
        OPEN,
        HOLD,
        RELEASE
    } gate_state_e;

endpackage

// File: rtl/stereo_peak_abs.sv
// Stereo peak detector: saturating magnitude of each channel, then the larger of the two.
module stereo_peak_abs #(
    parameter int WIDTH = 16
) (
    input  logic signed [WIDTH-1:0] left,
    input  logic signed [WIDTH-1:0] right,
    output logic        [WIDTH-1:0] mag
);

    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    // The most negative code has no positive twin, so it clamps to full scale.
    function automatic logic [WIDTH-1:0] sat_abs(input logic signed [WIDTH-1:0] x);
        logic [WIDTH-1:0] neg;
        neg = (~x) + ONE;
        if (!x[WIDTH-1]) begin
            sat_abs = x;
        end else if (neg[WIDTH-1]) begin
            sat_abs = MAX_POS;
        end else begin
            sat_abs = neg;
        end
    endfunction

    logic [WIDTH-1:0] abs_l;
    logic [WIDTH-1:0] abs_r;

    always_comb begin
        abs_l = sat_abs(left);
        abs_r = sat_abs(right);
        mag   = (abs_l >= abs_r) ? abs_l : abs_r;
    end

endmodule

// File: rtl/noise_gate.sv
// Stereo noise gate with open/close hysteresis, hold timer and linear attack/release gain ramps.
module noise_gate
    import audio_fx_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int THRESH_OPEN  = 2048,
    parameter int THRESH_CLOSE = 1536,
    parameter int HOLD_SAMPLES = 480,
    parameter int ATTACK_STEP  = 32,
    parameter int RELEASE_STEP = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    sample_en,
    input  logic signed [WIDTH-1:0] inleft,
    input  logic signed [WIDTH-1:0] inright,
    output logic signed [WIDTH-1:0] outleft,
    output logic signed [WIDTH-1:0] outright,
    output logic                    out_valid,
    output logic                    gate_open,
    output gain_t                   gain
);

    localparam int                HOLD_W    = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_SAMPLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_DEC  = HOLD_W'(1);
    localparam logic [WIDTH-1:0]  T_OPEN    = WIDTH'(THRESH_OPEN);
    localparam logic [WIDTH-1:0]  T_CLOSE   = WIDTH'(THRESH_CLOSE);
    localparam logic [9:0]        ATK_STEP  = 10'(ATTACK_STEP);
    localparam gain_t             REL_STEP  = gain_t'(RELEASE_STEP);

    gate_state_e        state_q, state_d;
    gain_t              gain_q, gain_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [WIDTH-1:0]   outleft_q, outleft_d;
    logic [WIDTH-1:0]   outright_q, outright_d;
    logic               out_valid_q, out_valid_d;

    logic [WIDTH-1:0]   mag;
    logic               loud;
    logic               quiet;
    logic [9:0]         gain_sum;
    gain_t              gain_up;
    gain_t              gain_dn;
    logic [WIDTH+9:0]   gain_ext;
    logic [WIDTH+9:0]   prod_l;
    logic [WIDTH+9:0]   prod_r;
    logic               prod_unused;

    stereo_peak_abs #(
        .WIDTH (WIDTH)
    ) u_peak (
        .left  (inleft),
        .right (inright),
        .mag   (mag)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= CLOSED;
            gain_q      <= '0;
            hold_q      <= '0;
            outleft_q   <= '0;
            outright_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gain_q      <= gain_d;
            hold_q      <= hold_d;
            outleft_q   <= outleft_d;
            outright_q  <= outright_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Saturating ramp values; gain_q never exceeds GAIN_ONE so 10 bits cannot overflow.
    always_comb begin
        loud     = (mag >= T_OPEN);
        quiet    = (mag < T_CLOSE);
        gain_sum = {1'b0, gain_q} + ATK_STEP;
        gain_up  = (gain_sum >= {1'b0, GAIN_ONE}) ? GAIN_ONE : gain_sum[8:0];
        gain_dn  = (gain_q <= REL_STEP) ? '0 : gain_q - REL_STEP;
    end

    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        hold_d  = hold_q;
        if (sample_en) begin
            case (state_q)
                CLOSED: begin
                    if (loud) begin
                        gain_d  = gain_up;
                        state_d = (gain_up == GAIN_ONE) ? OPEN : ATTACK;
                    end
                end
                ATTACK: begin
                    gain_d = gain_up;
                    if (gain_up == GAIN_ONE) state_d = OPEN;
                end
                OPEN: begin
                    if (quiet) begin
                        state_d = HOLD;
                        hold_d  = HOLD_LOAD;
                    end
                end
                HOLD: begin
                    if (loud)              state_d = OPEN;
                    else if (hold_q == '0) state_d = RELEASE;
                    else                   hold_d  = hold_q - HOLD_DEC;
                end
                RELEASE: begin
                    // A retrigger keeps the current gain so the new ramp resumes from it.
                    if (loud) begin
                        state_d = ATTACK;
                    end else begin
                        gain_d = gain_dn;
                        if (gain_dn == '0) state_d = CLOSED;
                    end
                end
                default: state_d = CLOSED;
            endcase
        end
    end

    // Unsigned multiply of fully extended operands yields the exact low bits of the signed product.
    always_comb begin
        gain_ext    = {{(WIDTH+1){1'b0}}, gain_q};
        prod_l      = {{10{inleft[WIDTH-1]}}, inleft} * gain_ext;
        prod_r      = {{10{inright[WIDTH-1]}}, inright} * gain_ext;
        out_valid_d = sample_en;
        outleft_d   = sample_en ? prod_l[WIDTH-1+GAIN_SHIFT:GAIN_SHIFT] : outleft_q;
        outright_d  = sample_en ? prod_r[WIDTH-1+GAIN_SHIFT:GAIN_SHIFT] : outright_q;
    end

    assign prod_unused = ^{prod_l[WIDTH+9:WIDTH+GAIN_SHIFT], prod_l[GAIN_SHIFT-1:0],
                           prod_r[WIDTH+9:WIDTH+GAIN_SHIFT], prod_r[GAIN_SHIFT-1:0]};

    always_comb begin
        outleft   = outleft_q;
        outright  = outright_q;
        out_valid = out_valid_q;
        gain      = gain_q;
        gate_open = (state_q != CLOSED);
    end

endmodule

// File: tb/tb_noise_gate.sv
// Self-checking bench for noise_gate: directed scenarios plus randomized traffic against a rule-level model.
module tb_noise_gate;

    localparam int HOLD_N = 4;
    localparam int P_CLOSED = 0, P_ATTACK = 1, P_OPEN = 2, P_HOLD = 3, P_RELEASE = 4;

    logic               clock;
    logic               reset;
    logic               sample_en;
    logic signed [15:0] inleft;
    logic signed [15:0] inright;
    logic signed [15:0] outleft;
    logic signed [15:0] outright;
    logic               out_valid;
    logic               gate_open;
    logic [8:0]         gain;

    int checks = 0;
    int errors = 0;

    int m_phase, m_gain, m_hold, m_outl, m_outr, m_valid;

    logic [42:0] dut_vec;
    logic [42:0] exp_q[$];

    noise_gate #(
        .WIDTH        (16),
        .THRESH_OPEN  (2048),
        .THRESH_CLOSE (1536),
        .HOLD_SAMPLES (HOLD_N),
        .ATTACK_STEP  (32),
        .RELEASE_STEP (1)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .sample_en (sample_en),
        .inleft    (inleft),
        .inright   (inright),
        .outleft   (outleft),
        .outright  (outright),
        .out_valid (out_valid),
        .gate_open (gate_open),
        .gain      (gain)
    );

    assign dut_vec = {outleft, outright, out_valid, gain, gate_open};

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int sat_mag(input int v);
        int a;
        a = (v < 0) ? -v : v;
        return (a > 32767) ? 32767 : a;
    endfunction

    function automatic int scale(input int x, input int g);
        int p, q;
        p = x * g;
        q = p / 256;
        if (p < 0 && (p % 256) != 0) q = q - 1;
        return q;
    endfunction

    function automatic logic [42:0] exp_vec();
        return {16'(m_outl), 16'(m_outr), 1'(m_valid), 9'(m_gain), (m_phase != P_CLOSED)};
    endfunction

    task automatic model_reset();
        m_phase = P_CLOSED; m_gain = 0; m_hold = 0;
        m_outl = 0; m_outr = 0; m_valid = 0;
    endtask

    task automatic model_update(input logic en, input int l, input int r);
        int mag;
        bit loud, quiet;
        if (!en) begin
            m_valid = 0;
            return;
        end
        m_outl  = scale(l, m_gain);
        m_outr  = scale(r, m_gain);
        m_valid = 1;
        mag   = (sat_mag(l) > sat_mag(r)) ? sat_mag(l) : sat_mag(r);
        loud  = (mag >= 2048);
        quiet = (mag < 1536);
        case (m_phase)
            P_CLOSED: if (loud) begin
                m_gain  = (m_gain + 32 > 256) ? 256 : m_gain + 32;
                m_phase = (m_gain == 256) ? P_OPEN : P_ATTACK;
            end
            P_ATTACK: begin
                m_gain = (m_gain + 32 > 256) ? 256 : m_gain + 32;
                if (m_gain == 256) m_phase = P_OPEN;
            end
            P_OPEN: if (quiet) begin
                m_phase = P_HOLD;
                m_hold  = HOLD_N - 1;
            end
            P_HOLD: begin
                if (loud)             m_phase = P_OPEN;
                else if (m_hold == 0) m_phase = P_RELEASE;
                else                  m_hold  = m_hold - 1;
            end
            default: begin
                if (loud) begin
                    m_phase = P_ATTACK;
                end else begin
                    m_gain = (m_gain - 1 < 0) ? 0 : m_gain - 1;
                    if (m_gain == 0) m_phase = P_CLOSED;
                end
            end
        endcase
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_step(input logic en, input logic signed [15:0] l, input logic signed [15:0] r);
        @(negedge clock);
        sample_en = en;
        inleft    = l;
        inright   = r;
        @(posedge clock);
        #1;
        model_update(en, int'(l), int'(r));
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset     = 1'b0;
        sample_en = 1'b1;
        inleft    = 16'sd5000;
        inright   = 16'sd5000;
        repeat (2) @(posedge clock);
        #1;
        model_reset();
        @(negedge clock);
        reset     = 1'b1;
        sample_en = 1'b0;
    endtask

    function automatic logic signed [15:0] rand_level(input int cls);
        int a;
        case (cls)
            0:       a = $urandom_range(0, 1535);
            1:       a = $urandom_range(1536, 2047);
            2:       a = $urandom_range(2048, 32767);
            default: return 16'($urandom);
        endcase
        if ($urandom_range(0, 1) == 1) a = -a;
        return 16'(a);
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge clock);
        reset     = 1'b0;
        sample_en = 1'b1;
        inleft    = 16'sd5000;
        inright   = 16'sd0;
        @(posedge clock);
        @(negedge clock);
        sample_en = 1'b0;
        @(posedge clock);
        #1;
        model_reset();
        checks++;
        if (dut_vec !== 43'd0) begin
            errors++;
            $display("FAIL reset_state: got %h required %h", dut_vec, 43'd0);
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_sub_threshold();
        for (int i = 0; i < 20; i++) begin
            drive_step(1'b1, 16'sd1000, -16'sd1500);
            checks++;
            if (dut_vec !== exp_vec() || gain !== 9'd0 || gate_open !== 1'b0 || outleft !== 16'sd0) begin
                errors++;
                $display("FAIL sub_threshold step %0d: got %h required %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_attack();
        for (int k = 1; k <= 9; k++) begin
            drive_step(1'b1, 16'sd4000, 16'sd0);
            checks++;
            if (dut_vec !== exp_vec() || outleft !== 16'((k - 1) * 500) ||
                gain !== 9'((k >= 8) ? 256 : k * 32)) begin
                errors++;
                $display("FAIL attack strobe %0d: got %h (outleft %0d gain %0d) required %h",
                         k, dut_vec, outleft, gain, exp_vec());
            end
        end
    endtask

    task automatic test_hold_release();
        for (int k = 1; k <= 262; k++) begin
            drive_step(1'b1, 16'sd100, 16'sd0);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL hold_release strobe %0d: got %h required %h", k, dut_vec, exp_vec());
            end
            if (k == 5 || k == 6 || k == 7 || k == 260 || k == 261) begin
                checks++;
                if ((k == 5 && (gain !== 9'd256 || outleft !== 16'sd100)) ||
                    (k == 6 && (gain !== 9'd255 || outleft !== 16'sd100)) ||
                    (k == 7 && outleft !== 16'sd99) ||
                    (k == 260 && gate_open !== 1'b1) ||
                    (k == 261 && (gate_open !== 1'b0 || gain !== 9'd0))) begin
                    errors++;
                    $display("FAIL hold_release_milestone %0d: got gain %0d outleft %0d gate_open %b",
                             k, gain, outleft, gate_open);
                end
            end
        end
    endtask

    task automatic test_retrigger();
        logic signed [15:0] lvl;
        for (int k = 0; k < 8 + 5 + 56 + 3 + 10 + 6; k++) begin
            if (k < 8)            lvl = 16'sd4000;
            else if (k < 69)      lvl = 16'sd100;
            else if (k < 72)      lvl = 16'sd3000;
            else if (k < 82)      lvl = 16'sd1800;
            else                  lvl = 16'sd100;
            drive_step(1'b1, lvl, 16'sd0);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL retrigger step %0d: got %h required %h", k, dut_vec, exp_vec());
            end
            if (k == 68 || k == 69 || k == 70 || k == 71 || k == 86 || k == 87) begin
                checks++;
                if ((k == 68 && gain !== 9'd200) || (k == 69 && (gain !== 9'd200 || outleft !== 16'sd2343)) ||
                    (k == 70 && gain !== 9'd232) || (k == 71 && gain !== 9'd256) ||
                    (k == 86 && gain !== 9'd256) || (k == 87 && gain !== 9'd255)) begin
                    errors++;
                    $display("FAIL retrigger_milestone %0d: got gain %0d outleft %0d", k, gain, outleft);
                end
            end
        end
    endtask

    task automatic test_edge_min();
        do_reset();
        for (int k = 1; k <= 9; k++) begin
            drive_step(1'b1, 16'sd0, -16'sd32768);
            checks++;
            if (dut_vec !== exp_vec() || gate_open !== 1'b1) begin
                errors++;
                $display("FAIL edge_min strobe %0d: got %h required %h", k, dut_vec, exp_vec());
            end
        end
        checks++;
        if (outright !== -16'sd32768 || gain !== 9'd256) begin
            errors++;
            $display("FAIL edge_min_unity: got outright %0d gain %0d required -32768 and 256", outright, gain);
        end
    endtask

    task automatic test_freeze_and_reset();
        do_reset();
        for (int k = 0; k < 3; k++) drive_step(1'b1, 16'sd4000, 16'sd0);
        for (int k = 0; k < 10; k++) begin
            drive_step(1'b0, 16'($urandom), 16'($urandom));
            checks++;
            if (dut_vec !== exp_vec() || gain !== 9'd96 || out_valid !== 1'b0 || outleft !== 16'sd1000) begin
                errors++;
                $display("FAIL freeze cycle %0d: got %h required %h", k, dut_vec, exp_vec());
            end
        end
        drive_step(1'b1, 16'sd4000, 16'sd0);
        checks++;
        if (dut_vec !== exp_vec() || outleft !== 16'sd1500 || gain !== 9'd128) begin
            errors++;
            $display("FAIL freeze_resume: got %h required %h", dut_vec, exp_vec());
        end
        @(negedge clock);
        reset     = 1'b0;
        sample_en = 1'b1;
        inleft    = 16'sd4000;
        @(posedge clock);
        #1;
        model_reset();
        checks++;
        if (dut_vec !== 43'd0) begin
            errors++;
            $display("FAIL reset_mid_attack: got %h required %h", dut_vec, 43'd0);
        end
        @(negedge clock);
        reset     = 1'b1;
        sample_en = 1'b0;
    endtask

    task automatic test_random();
        int cls_l, cls_r, run;
        logic [42:0] exp;
        run = 0;
        cls_l = 0;
        cls_r = 0;
        for (int i = 0; i < 4000; i++) begin
            if (run == 0) begin
                cls_l = $urandom_range(0, 3);
                cls_r = ($urandom_range(0, 3) == 0) ? cls_l : 0;
                run   = (cls_l == 0) ? $urandom_range(1, 300) : $urandom_range(1, 40);
            end
            run--;
            drive_step($urandom_range(0, 4) != 0, rand_level(cls_l), rand_level(cls_r));
            exp_q.push_back(exp_vec());
            exp = exp_q.pop_front();
            checks++;
            if (dut_vec !== exp) begin
                errors++;
                $display("FAIL random step %0d: got %h required %h", i, dut_vec, exp);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset     = 1'b0;
        sample_en = 1'b0;
        inleft    = '0;
        inright   = '0;
        model_reset();
        test_reset();
        test_sub_threshold();
        test_attack();
        test_hold_release();
        test_retrigger();
        test_edge_min();
        test_freeze_and_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/noise_gate.md
Name: noise_gate

Overview:
- Stereo downstream-of-codec, upstream-of-compressor noise gate; its outleft/outright feed the compressor's inleft/inright directly.
- Mutes low-level input hiss when the stereo peak falls below a threshold, using open/close hysteresis, a hold timer and linear attack/release gain ramps to avoid clicks.
- Processes one stereo sample per sample_en strobe.

Parameters:
WIDTH, 16, signed sample width per channel
THRESH_OPEN, 2048, magnitude at or above which the gate opens
THRESH_CLOSE, 1536, magnitude below which the open gate starts its hold; must be ≤ THRESH_OPEN
HOLD_SAMPLES, 480, samples the gate stays fully open after level drops (10 ms at 48 kHz); ≥1
ATTACK_STEP, 32, gain increment per sample in ATTACK
RELEASE_STEP, 1, gain decrement per sample in RELEASE

Ports:
clock  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-low reset
sample_en  in  1  one-cycle strobe: a new sample is present on inleft/inright
inleft  in  WIDTH  signed left sample
inright  in  WIDTH  signed right sample
outleft  out  WIDTH  signed gated left sample
outright  out  WIDTH  signed gated right sample
out_valid  out  1  high for one cycle when outleft/outright update
gate_open  out  1  high whenever state ≠ CLOSED
gain  out  9  current gain, 0..256 (256 = unity)

Behaviour:
- Reset (reset==0 at posedge): state CLOSED, gain 0, hold counter 0, outleft/outright 0, out_valid 0, gate_open 0. It overrides sample_en and aborts any ramp immediately.
- Cycles with sample_en==0: all state and outputs hold; out_valid is 0.
- Magnitude: mag = max(|inleft|, |inright|). |−2^(WIDTH−1)| saturates to 2^(WIDTH−1)−1.
- Output latency is 1 clock. On a sample_en edge: out = (in × gain_reg) >>> 8, where gain_reg is the value before this edge's update.
  - The product is WIDTH+10 bits signed, with an arithmetic shift (floor).
  - Gain 256 passes the input bit-exact. Gain 0 gives 0.
  - out_valid is 1 in the following cycle.
- State machine, evaluated only on sample_en:
  - CLOSED: gain 0. If mag ≥ THRESH_OPEN, go to ATTACK.
  - ATTACK: gain = min(gain + ATTACK_STEP, 256). When the new gain is 256, go to OPEN. Level is ignored while ramping up.
  - OPEN: gain 256. If mag < THRESH_CLOSE, go to HOLD and load counter = HOLD_SAMPLES−1.
  - HOLD: gain 256.
    - If mag ≥ THRESH_OPEN, go to OPEN.
    - Else if counter == 0, go to RELEASE.
    - Else counter−1.
  - RELEASE: gain = max(gain − RELEASE_STEP, 0).
    - If mag ≥ THRESH_OPEN, go to ATTACK; no decrement on that sample, and the next ramp starts from the current gain.
    - Else, when the new gain is 0, go to CLOSED.
- Hysteresis band (THRESH_CLOSE ≤ mag < THRESH_OPEN) causes no transition in any state.
- Simultaneous events: the retrigger check takes priority over hold expiry and over release completion.
- Gain register saturates at both ends; no wrap.

Decomposition:
- Shared package audio_fx_pkg:
  - sample_t (logic signed [WIDTH−1:0])
  - gain_t (logic [8:0])
  - GAIN_ONE = 256, GAIN_SHIFT = 8
  - gate_state_e enum {CLOSED, ATTACK, OPEN, HOLD, RELEASE}
- One sub-module, stereo_peak_abs: combinational saturating abs of both channels plus max. It is reused by the future limiter/meter blocks.
- Gain multiply and FSM stay in noise_gate.

Test Plan:
1. Reset: hold reset=0 for 2 clocks with inleft=5000 and sample_en pulsing → outleft=outright=0, gain=0, gate_open=0, out_valid=0.
2. Sub-threshold: inleft=1000, inright=−1500 for 20 strobes → outputs stay 0, gate_open=0, gain=0.
3. Attack: inleft=4000, inright=0, strobe every cycle → gain 32,64,…,256 over 8 strobes. outleft sequence is 0,500,1000,…,3500, then 4000. OPEN is reached after strobe 8.
4. Hold/release (HOLD_SAMPLES=4): from OPEN, inleft=100 → four more outputs of 100 at gain 256, then gain 255,254,… per strobe. CLOSED and gate_open=0 are reached after 256 release strobes. outleft floors (100×255>>>8 = 99).
5. Retrigger: in RELEASE at gain 200, apply inleft=3000 → ATTACK with gain 200, 232, 256, then OPEN. The hysteresis value 1800 during OPEN causes no HOLD entry.
6. Edge cases, each with the listed response:
   - inright=−32768, inleft=0 → gate opens (mag 32767); at gain 256, outright = −32768 exactly.
   - sample_en held low for 10 cycles mid-ATTACK → gain and outputs frozen, out_valid low.
   - reset=0 mid-ATTACK → CLOSED, gain 0 on the next cycle.
